// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the synchronous 2-read/1-write register file.
package reg_file_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_LANES      = 64;
  localparam int unsigned DATA_IDX_W     = $clog2(MAX_DATA_WIDTH);
  localparam int unsigned LANE_IDX_W     = $clog2(MAX_LANES);

  function automatic int unsigned num_lanes(input int unsigned data_width,
                                            input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

  // Callers zero-extend into the max-width container and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      lane_en,
    input int unsigned               lane_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (lane_en[LANE_IDX_W'(i / lane_width)]) begin
        merged[DATA_IDX_W'(i)] = new_word[DATA_IDX_W'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: sweeps every address with a zero write after reset or on request.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= addr_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = clr_addr;
    busy       = 1'b0;
    clear_done = 1'b0;
    clr_we     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          addr_next  = '0;
        end
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        // No array write or done pulse on a reset edge; the sweep restarts instead.
        clr_we     = !rst;
        clear_done = !rst && (clr_addr == LAST_ADDR);
        addr_next  = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == LAST_ADDR) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/reg_file_2r1w_sync.sv
// Synchronous register file: one lane-masked write port, two registered read ports with bypass.
module reg_file_2r1w_sync
  import reg_file_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ADDR_WIDTH = 5,
  parameter  int unsigned LANE_WIDTH = 4,
  localparam int unsigned NUM_LANES  = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_lane_en,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b
);

  localparam int unsigned MEM_SIZE = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  wr_fire;
  logic                  rd_fire_a;
  logic                  rd_fire_b;

  reg_file_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  // The merged word feeds both the array write and the same-address bypass.
  always_comb begin
    wr_word = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[wr_addr]),
                                     MAX_DATA_WIDTH'(wr_data),
                                     MAX_LANES'(wr_lane_en),
                                     LANE_WIDTH));
  end

  assign wr_fire   = wr_en   && !busy && !rst;
  assign rd_fire_a = rd_en_a && !busy && !rst;
  assign rd_fire_b = rd_en_b && !busy && !rst;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_a <= rd_fire_a;
      rd_valid_b <= rd_fire_b;
      if (rd_fire_a) begin
        rd_data_a <= (wr_fire && (wr_addr == rd_addr_a)) ? wr_word : mem[rd_addr_a];
      end
      if (rd_fire_b) begin
        rd_data_b <= (wr_fire && (wr_addr == rd_addr_b)) ? wr_word : mem[rd_addr_b];
      end
    end
  end

endmodule

// File: doc/reg_file_2r1w_sync.md
Name: reg_file_2r1w_sync

Overview:
Synchronous register file with one write port and two independent read ports. It replaces the asynchronous tristate single-port register file for datapath use. Features:
- per-lane write enables
- registered reads with a valid flag
- write-to-read bypass
- a hardware clear sequencer that zeroes the array after reset or on request

It sits between the control unit and the ALU operand muxes.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH
ADDR_WIDTH, 5, address width; depth MEM_SIZE = 2**ADDR_WIDTH
LANE_WIDTH, 4, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
clear_req  input  1  one-cycle request to zero the whole array
busy  output  1  high while the clear sequencer runs
clear_done  output  1  one-cycle pulse on the last clear write
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_lane_en  input  NUM_LANES  per-lane write enable; bit k covers bits [k*LANE_WIDTH +: LANE_WIDTH]
rd_en_a  input  1  port A read request
rd_addr_a  input  ADDR_WIDTH  port A address
rd_data_a  output  DATA_WIDTH  port A read data
rd_valid_a  output  1  port A data valid
rd_en_b, rd_addr_b, rd_data_b, rd_valid_b  (same as port A)

Behaviour:
- Reset, while rst=1 at a clk edge:
  - FSM forced to CLEAR, clr_addr=0.
  - busy=1, clear_done=0.
  - rd_data_a/b=0, rd_valid_a/b=0.
  - The array is not written during rst.
- FSM states IDLE and CLEAR:
  - CLEAR: each cycle with rst=0, write 0 to mem[clr_addr] and increment clr_addr. When clr_addr==MEM_SIZE-1, write it, pulse clear_done=1 that cycle, and go to IDLE the next cycle.
  - After rst falls, busy stays high for exactly MEM_SIZE cycles.
  - IDLE: busy=0. clear_req=1 → CLEAR, clr_addr=0, busy=1 from the next cycle.
  - clear_req in CLEAR is ignored; the sweep does not restart.
- While busy=1:
  - wr_en is ignored (write dropped, no error flag).
  - rd_en_x is ignored: rd_valid_x=0, rd_data_x holds its value.
- Write (IDLE, wr_en=1): at the clk edge, for each lane k with wr_lane_en[k]=1, update that lane of mem[wr_addr]. Lanes with 0 keep their old value. wr_lane_en=0 is a no-op.
- Read (IDLE, rd_en_x=1): rd_data_x = mem[rd_addr_x] is registered at the clk edge and visible the next cycle with rd_valid_x=1 (1-cycle latency).
  - rd_en_x=0: rd_valid_x=0 next cycle; rd_data_x holds the last value.
- Bypass: a same-cycle read and write to the same address returns the post-write word, i.e. new lanes merged with old lanes per wr_lane_en. Ports A and B bypass independently.
- Both ports may read the same address in the same cycle; both return identical data.
- Address width is exact; no out-of-range case exists. clr_addr wraps naturally but the FSM exits before the wrap.
- rst asserted mid-CLEAR or mid-IDLE: same as a power-on reset. The sweep restarts at 0; any write on that edge is dropped.
- No tristate outputs; there are no X or Z values on any output after the first reset.

Decomposition:
- Shared package/include `reg_file_pkg`:
  - state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1
  - a function computing NUM_LANES
  - a lane-merge function (old word, new word, lane enables → merged word) used by both the write path and the bypass
- One natural sub-module: `reg_file_clear_seq` (FSM, clr_addr counter, busy, clear_done).
- The array and the read ports stay in the top module.

Test Plan:
1. Defaults. Pulse rst for 2 cycles, release. busy=1 for exactly 32 cycles, clear_done pulses on cycle 32. Then read all 32 addresses on A and B: every rd_data=0x00, rd_valid=1 one cycle after each rd_en.
2. Lane writes:
   - write addr 5 data 0xA5 lanes 2'b11 → read 0xA5
   - write addr 5 data 0x3C lanes 2'b01 → read 0xAC
   - lanes 2'b00 → still 0xAC
3. Bypass:
   - mem[7]=0x11. Same cycle: write addr 7 data 0xF0 lanes 2'b10 with rd_addr_a=7 and rd_addr_b=7 → next cycle both ports read 0xF1.
   - A later read of addr 7 → 0xF1.
4. Busy lockout: fill addr 3 with 0x55, pulse clear_req, then issue a write (addr 3, 0x99) and a read during busy.
   - rd_valid stays 0, write dropped.
   - After clear_done, addr 3 reads 0x00.
   - A second clear_req mid-sweep does not extend busy beyond 32 cycles.
5. Reset mid-sweep: assert rst at sweep cycle 10 for 1 cycle → busy remains 1 for a fresh 32 cycles after release; rd_valid_a/b=0 during rst.
6. Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3, LANE_WIDTH=8.
   - busy lasts 8 cycles.
   - write 0xBEEF lanes 2'b10 over 0x1234 → reads 0xBE34.
